// File: rtl/interval_meter_pkg.sv
// Shared definitions for the interval meter: FSM state encoding and default counter width.
package interval_meter_pkg;

    localparam int CNT_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous line plus a delayed copy for rising-edge detection.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain and previous-value flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out   = sync_r;
    assign rise_pulse = sync_r & ~prev_r;

endmodule

// File: rtl/interval_meter.sv
// Measures clk cycles between consecutive rising edges of event_in, with timeout and a valid/ready result.
// Optional min/max tracking outputs are enabled by defining INTERVAL_MINMAX_EN.
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int                   CNT_WIDTH     = CNT_WIDTH_DEFAULT,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = 10'd1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 meas_en,
    input  logic                 event_in,
    input  logic                 meas_ready,
    output logic                 meas_valid,
    output logic [CNT_WIDTH-1:0] meas_cnt,
    output logic                 meas_timeout,
    output logic                 meas_lost,
`ifdef INTERVAL_MINMAX_EN
    output logic [CNT_WIDTH-1:0] meas_min,
    output logic [CNT_WIDTH-1:0] meas_max,
`endif
    output logic                 meas_busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};

    state_e               state_r;
    state_e               state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 rise_s;
    logic                 new_res_s;
    logic                 timeout_s;
    logic                 arm_start_s;
    logic                 transfer_s;
    logic                 valid_r;
    logic [CNT_WIDTH-1:0] res_r;
    logic                 timeout_r;
    logic                 lost_r;
    logic                 busy_r;

    edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (event_in),
        .sync_out   (),
        .rise_pulse (rise_s)
    );

    // Next-state and interval counter logic; the edge check precedes the timeout check so a tie yields a result.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        new_res_s   = 1'b0;
        timeout_s   = 1'b0;
        arm_start_s = 1'b0;
        if (!meas_en) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ARM;
                    cnt_nxt_s   = CNT_ZERO;
                    arm_start_s = 1'b1;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                ST_RUN: begin
                    if (rise_s) begin
                        new_res_s = 1'b1;
                        cnt_nxt_s = CNT_ONE;
                    end else if (cnt_r == TIMEOUT_LIMIT) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = ST_ARM;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    assign transfer_s = valid_r & meas_ready;

    // State, counter, timeout pulse and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            timeout_r <= timeout_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Result register: a full register without a same-cycle transfer drops the new interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            res_r   <= CNT_ZERO;
            lost_r  <= 1'b0;
        end else begin
            if (new_res_s && (!valid_r || transfer_s)) begin
                valid_r <= 1'b1;
                res_r   <= cnt_r;
            end else if (transfer_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (transfer_s) begin
                lost_r <= 1'b0;
            end else if (new_res_s && valid_r) begin
                lost_r <= 1'b1;
            end else begin
                lost_r <= lost_r;
            end
        end
    end

`ifdef INTERVAL_MINMAX_EN
    logic [CNT_WIDTH-1:0] min_r;
    logic [CNT_WIDTH-1:0] max_r;

    // Running extremes over every completed interval, dropped ones included; restart on each arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r <= CNT_ONES;
            max_r <= CNT_ZERO;
        end else if (arm_start_s) begin
            min_r <= CNT_ONES;
            max_r <= CNT_ZERO;
        end else if (new_res_s) begin
            if (cnt_r < min_r) begin
                min_r <= cnt_r;
            end else begin
                min_r <= min_r;
            end
            if (cnt_r > max_r) begin
                max_r <= cnt_r;
            end else begin
                max_r <= max_r;
            end
        end else begin
            min_r <= min_r;
            max_r <= max_r;
        end
    end

    assign meas_min = min_r;
    assign meas_max = max_r;
`else
    logic unused_arm_start_s;
    assign unused_arm_start_s = arm_start_s;
`endif

    assign meas_valid   = valid_r;
    assign meas_cnt     = res_r;
    assign meas_timeout = timeout_r;
    assign meas_lost    = lost_r;
    assign meas_busy    = busy_r;

endmodule
